tank_motion: RTL and testbench
==============================

# tank_motion

Per-tank motion and fire controller for the arena: samples the 4-slot USB keycode word once per frame and updates a clamped tank position, a heading, and a debounced fire pulse. It generalises the single-ball mover. Key bindings, arena bounds, step size, coordinate width and fire cooldown are all parameters, so one module serves both tanks. Outputs feed the sprite renderer, the projectile spawner and collision logic.

## Interface
- COORD_W, 10, coordinate width in bits
- X_CENTER / Y_CENTER, 300 / 250, reset position
- X_MIN / X_MAX, 0 / 639, horizontal arena bounds (inclusive)
- Y_MIN / Y_MAX, 0 / 479, vertical arena bounds (inclusive)
- SIZE, 4, tank half-extent
- STEP, 1, pixels moved per frame per axis
- KEY_UP / KEY_DOWN / KEY_LEFT / KEY_RIGHT, 8'h52 / 8'h51 / 8'h50 / 8'h4F, movement scancodes
- KEY_FIRE, 8'h2C, fire scancode
- COOLDOWN, 16, frames of fire lockout after a shot; must be ≥1
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-high
- keycode  in  32  four USB scancode slots, [31:24]..[7:0]
- TankX, TankY  out  COORD_W  tank centre position
- TankS  out  COORD_W  constant SIZE
- Heading  out  3  direction: 0=N, 1=NE, 2=E, 3=SE, 4=S, 5=SW, 6=W, 7=NW
- Fire  out  1  one-frame shot pulse
- Ready  out  1  high when a shot can be fired

## Operation
- A key is "pressed" if its scancode appears in any of the 4 slots. Slot order is irrelevant.
- Without diagonal support, one direction is selected by priority: up > down > left > right. No key selected means no motion. There is no momentum.
- Motion is applied in the same edge it is decoded: next position = current position ± STEP on the selected axis. A key change is reflected in TankX/TankY on the very next edge; there is no one-frame stale-motion lag.
- Clamp per axis:
  - If pos − STEP − SIZE < MIN, then pos ← MIN + SIZE.
  - If pos + STEP + SIZE > MAX, then pos ← MAX − SIZE.
  - Compare in COORD_W+1-bit signed arithmetic so the result never wraps through 0.
- Heading follows the selected direction even when the move is clamped. With no key pressed, Heading holds its value.
- Fire FSM, states READY and COOL:
  - READY: if fire is pressed now and was not pressed at the previous edge, then Fire←1, cnt←COOLDOWN, go to COOL.
  - COOL: Fire←0 and cnt decrements each edge; at cnt==1 go to READY.
  - Ready = (state==READY).
  - Holding fire produces exactly one shot. A press held across the end of cooldown does not fire; a fresh press is required.
  - The previous-fire flag updates every edge, in every state.
- Movement and fire are independent: firing while moving is allowed.

## Timing
- Reset values: TankX=X_CENTER, TankY=Y_CENTER, TankS=SIZE, Heading=0, Fire=0, Ready=1, state READY, cnt=0, previous-fire flag=0.
- Reset may arrive mid-cooldown or mid-move. All registers return to their reset values immediately, and there is no pending shot.
- Latency is one frame_clk edge from keycode to every output. keycode is only sampled at the edge, so glitches between edges are ignored.
- Fire is high for exactly one frame. Ready is low for exactly COOLDOWN frames, starting at the edge where Fire rises.
- Opposing keys (up+down, or left+right) resolve by priority; they never cancel each other out.

## Configuration
- TANK_DIAG_EN defined:
  - The vertical pair (up > down) and the horizontal pair (left > right) resolve independently, and both axes move in the same frame.
  - Each axis is clamped independently.
  - Heading can take all 8 values.
- TANK_DIAG_EN undefined:
  - Single-axis priority as above.
  - Heading only takes 0, 2, 4, 6.

## Structure
- tank_pkg holds:
  - the heading_t enum (3-bit, N..NW);
  - the fire_state_t enum (READY, COOL);
  - default scancode constants (arrows, WASD, space).
- One sub-module, tank_key_decode: a combinational 4-slot matcher that returns up/down/left/right/fire pressed bits. It is instantiated once, inside tank_motion.

## Test plan
- Reset → TankX=300, TankY=250, Heading=0, Ready=1, Fire=0. Then hold 8'h4F in slot [15:8] for 10 edges → TankX=310, TankY=250, Heading=2.
- Hold 8'h50 for 400 edges from reset → TankX decreases to 4 and stays at 4; Heading=6; no wrap to large values.
- Press 8'h2C and hold for 40 edges → Fire high for exactly one edge, Ready=0 for 16 edges, no second pulse. Release, then press again → a second single pulse.
- Apply 8'h52 and 8'h4F together for 5 edges:
  - without TANK_DIAG_EN → TankY=245, TankX=300, Heading=0;
  - with TANK_DIAG_EN → TankX=305, TankY=245, Heading=1.
- Apply 8'h52 and 8'h51 together → TankY decrements (up wins). Reset asserted mid-cooldown → Ready=1, Fire=0 and position back at centre immediately.

Source files
------------

// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared types, scancodes and key-match helper for the tank motion block
package tank_pkg;

    // Compass heading, clockwise from north
    typedef enum logic [2:0] {
        HEAD_N  = 3'd0,
        HEAD_NE = 3'd1,
        HEAD_E  = 3'd2,
        HEAD_SE = 3'd3,
        HEAD_S  = 3'd4,
        HEAD_SW = 3'd5,
        HEAD_W  = 3'd6,
        HEAD_NW = 3'd7
    } heading_t;

    // Fire controller states
    typedef enum logic [0:0] {
        FIRE_READY = 1'b0,
        FIRE_COOL  = 1'b1
    } fire_state_t;

    // Arrow keys (player one defaults)
    localparam logic [7:0] SC_ARROW_UP    = 8'h52;
    localparam logic [7:0] SC_ARROW_DOWN  = 8'h51;
    localparam logic [7:0] SC_ARROW_LEFT  = 8'h50;
    localparam logic [7:0] SC_ARROW_RIGHT = 8'h4F;

    // WASD (player two bindings)
    localparam logic [7:0] SC_W = 8'h1A;
    localparam logic [7:0] SC_A = 8'h04;
    localparam logic [7:0] SC_S = 8'h16;
    localparam logic [7:0] SC_D = 8'h07;

    localparam logic [7:0] SC_SPACE = 8'h2C;

    // True when code sits in any of the four scancode slots
    function automatic logic key_hit(input logic [31:0] kc, input logic [7:0] code);
        return (kc[31:24] == code) || (kc[23:16] == code) ||
               (kc[15:8]  == code) || (kc[7:0]   == code);
    endfunction

endpackage

// File: rtl/tank_key_decode.sv
// rtl/tank_key_decode.sv - combinational 4-slot scancode matcher for movement and fire keys
module tank_key_decode
    import tank_pkg::*;
#(
    parameter logic [7:0] KEY_UP    = SC_ARROW_UP,
    parameter logic [7:0] KEY_DOWN  = SC_ARROW_DOWN,
    parameter logic [7:0] KEY_LEFT  = SC_ARROW_LEFT,
    parameter logic [7:0] KEY_RIGHT = SC_ARROW_RIGHT,
    parameter logic [7:0] KEY_FIRE  = SC_SPACE
) (
    input  logic [31:0] keycode,
    output logic        up,
    output logic        down,
    output logic        left,
    output logic        right,
    output logic        fire
);

    // Slot order is irrelevant: a key is pressed if any slot holds it
    always_comb begin
        up    = key_hit(keycode, KEY_UP);
        down  = key_hit(keycode, KEY_DOWN);
        left  = key_hit(keycode, KEY_LEFT);
        right = key_hit(keycode, KEY_RIGHT);
        fire  = key_hit(keycode, KEY_FIRE);
    end

endmodule

// File: rtl/tank_motion.sv
// rtl/tank_motion.sv - per-tank clamped motion, heading and fire cooldown; TANK_DIAG_EN enables diagonal moves
module tank_motion
    import tank_pkg::*;
#(
    parameter int         COORD_W   = 10,
    parameter int         X_CENTER  = 300,
    parameter int         Y_CENTER  = 250,
    parameter int         X_MIN     = 0,
    parameter int         X_MAX     = 639,
    parameter int         Y_MIN     = 0,
    parameter int         Y_MAX     = 479,
    parameter int         SIZE      = 4,
    parameter int         STEP      = 1,
    parameter logic [7:0] KEY_UP    = SC_ARROW_UP,
    parameter logic [7:0] KEY_DOWN  = SC_ARROW_DOWN,
    parameter logic [7:0] KEY_LEFT  = SC_ARROW_LEFT,
    parameter logic [7:0] KEY_RIGHT = SC_ARROW_RIGHT,
    parameter logic [7:0] KEY_FIRE  = SC_SPACE,
    parameter int         COOLDOWN  = 16
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic [31:0]        keycode,
    output logic [COORD_W-1:0] TankX,
    output logic [COORD_W-1:0] TankY,
    output logic [COORD_W-1:0] TankS,
    output logic [2:0]         Heading,
    output logic               Fire,
    output logic               Ready
);

    // Two spare bits keep pos+STEP+SIZE and pos-STEP-SIZE from wrapping for any pos
    localparam int CW    = COORD_W + 2;
    localparam int CNT_W = $clog2(COOLDOWN + 1);

    localparam logic [0:0] ST_READY = FIRE_READY;
    localparam logic [0:0] ST_COOL  = FIRE_COOL;

    // Clamp thresholds: moving down-axis clamps when pos < MIN+SIZE+STEP, up-axis when pos > MAX-SIZE-STEP
    localparam logic signed [CW-1:0] X_LO_LIM = CW'(X_MIN + SIZE + STEP);
    localparam logic signed [CW-1:0] X_HI_LIM = CW'(X_MAX - SIZE - STEP);
    localparam logic signed [CW-1:0] X_LO_POS = CW'(X_MIN + SIZE);
    localparam logic signed [CW-1:0] X_HI_POS = CW'(X_MAX - SIZE);
    localparam logic signed [CW-1:0] Y_LO_LIM = CW'(Y_MIN + SIZE + STEP);
    localparam logic signed [CW-1:0] Y_HI_LIM = CW'(Y_MAX - SIZE - STEP);
    localparam logic signed [CW-1:0] Y_LO_POS = CW'(Y_MIN + SIZE);
    localparam logic signed [CW-1:0] Y_HI_POS = CW'(Y_MAX - SIZE);
    localparam logic signed [CW-1:0] STEP_S   = CW'(STEP);

    logic key_up, key_down, key_left, key_right, key_fire;
    logic mv_up, mv_down, mv_left, mv_right;

    logic [COORD_W-1:0] next_x, next_y;
    heading_t           heading, next_heading;

    logic [0:0]       fire_state;
    logic [CNT_W-1:0] cnt;
    logic             prev_fire;

    tank_key_decode #(
        .KEY_UP    (KEY_UP),
        .KEY_DOWN  (KEY_DOWN),
        .KEY_LEFT  (KEY_LEFT),
        .KEY_RIGHT (KEY_RIGHT),
        .KEY_FIRE  (KEY_FIRE)
    ) u_key_decode (
        .keycode (keycode),
        .up      (key_up),
        .down    (key_down),
        .left    (key_left),
        .right   (key_right),
        .fire    (key_fire)
    );

    // One step along an axis, snapped to the bound instead of crossing it
    function automatic logic [COORD_W-1:0] axis_next(
        input logic [COORD_W-1:0]    pos,
        input logic                  dec,
        input logic                  inc,
        input logic signed [CW-1:0]  lo_lim,
        input logic signed [CW-1:0]  hi_lim,
        input logic signed [CW-1:0]  lo_pos,
        input logic signed [CW-1:0]  hi_pos
    );
        logic signed [CW-1:0] p;
        logic signed [CW-1:0] n;
        p = signed'({2'b00, pos});
        n = p;
        if (dec) begin
            n = (p < lo_lim) ? lo_pos : (p - STEP_S);
        end else if (inc) begin
            n = (p > hi_lim) ? hi_pos : (p + STEP_S);
        end
        return n[COORD_W-1:0];
    endfunction

`ifdef TANK_DIAG_EN
    // Each axis resolves its own opposing pair, so both axes may move together
    always_comb begin
        mv_up    = key_up;
        mv_down  = !key_up && key_down;
        mv_left  = key_left;
        mv_right = !key_left && key_right;
    end
`else
    // Single direction by priority up > down > left > right
    always_comb begin
        mv_up    = key_up;
        mv_down  = !key_up && key_down;
        mv_left  = !key_up && !key_down && key_left;
        mv_right = !key_up && !key_down && !key_left && key_right;
    end
`endif

    // Next position and heading come straight from this edge's keys, no lag
    always_comb begin
        next_x       = axis_next(TankX, mv_left, mv_right, X_LO_LIM, X_HI_LIM, X_LO_POS, X_HI_POS);
        next_y       = axis_next(TankY, mv_up, mv_down, Y_LO_LIM, Y_HI_LIM, Y_LO_POS, Y_HI_POS);
        next_heading = heading;
        case ({mv_up, mv_down, mv_left, mv_right})
            4'b1000: next_heading = HEAD_N;
            4'b1001: next_heading = HEAD_NE;
            4'b0001: next_heading = HEAD_E;
            4'b0101: next_heading = HEAD_SE;
            4'b0100: next_heading = HEAD_S;
            4'b0110: next_heading = HEAD_SW;
            4'b0010: next_heading = HEAD_W;
            4'b1010: next_heading = HEAD_NW;
            default: next_heading = heading;
        endcase
    end

    // Position and heading registers
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            TankX   <= COORD_W'(X_CENTER);
            TankY   <= COORD_W'(Y_CENTER);
            heading <= HEAD_N;
        end else begin
            TankX   <= next_x;
            TankY   <= next_y;
            heading <= next_heading;
        end
    end

    // Fire controller: rising-edge press fires once, then locks out for COOLDOWN frames
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            fire_state <= ST_READY;
            cnt        <= '0;
            prev_fire  <= 1'b0;
            Fire       <= 1'b0;
        end else begin
            prev_fire <= key_fire;
            Fire      <= 1'b0;
            case (fire_state)
                ST_READY: begin
                    if (key_fire && !prev_fire) begin
                        Fire       <= 1'b1;
                        cnt        <= CNT_W'(COOLDOWN);
                        fire_state <= ST_COOL;
                    end
                end
                default: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        fire_state <= ST_READY;
                    end
                end
            endcase
        end
    end

    assign TankS   = COORD_W'(SIZE);
    assign Heading = heading;
    assign Ready   = (fire_state == ST_READY);

endmodule

// File: tb/tb_tank_motion.sv
// tb/tb_tank_motion.sv - directed self-checking bench for tank_motion
module tb_tank_motion;

    logic        frame_clk;
    logic        Reset;
    logic [31:0] keycode;
    logic [9:0]  TankX, TankY, TankS;
    logic [2:0]  Heading;
    logic        Fire, Ready;

    int tests_run    = 0;
    int tests_failed = 0;

    tank_motion dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .TankX     (TankX),
        .TankY     (TankY),
        .TankS     (TankS),
        .Heading   (Heading),
        .Fire      (Fire),
        .Ready     (Ready)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, return at the following falling edge
    task automatic step(input int n);
        repeat (n) @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    task automatic do_reset();
        keycode = 32'h0;
        Reset   = 1'b1;
        step(1);
        Reset = 1'b0;
    endtask

    int fire_cnt;
    int not_ready_cnt;

    initial begin
        Reset   = 1'b1;
        keycode = 32'h0;
        step(1);

        check("rst_x", int'(TankX), 300);
        check("rst_y", int'(TankY), 250);
        check("rst_s", int'(TankS), 4);
        check("rst_heading", int'(Heading), 0);
        check("rst_ready", int'(Ready), 1);
        check("rst_fire", int'(Fire), 0);

        // Right for 10 edges
        Reset   = 1'b0;
        keycode = 32'h0000_4F00;
        step(10);
        check("right10_x", int'(TankX), 310);
        check("right10_y", int'(TankY), 250);
        check("right10_heading", int'(Heading), 2);

        // No key: no momentum, heading holds
        keycode = 32'h0;
        step(3);
        check("idle_x", int'(TankX), 310);
        check("idle_heading", int'(Heading), 2);

        // Glitch between edges is not sampled
        keycode = 32'h5200_0000;
        #2 keycode = 32'h0;
        step(1);
        check("glitch_y", int'(TankY), 250);

        // Left clamp
        do_reset();
        keycode = 32'h5000_0000;
        step(295);
        check("left295_x", int'(TankX), 5);
        step(1);
        check("left296_x", int'(TankX), 4);
        step(104);
        check("left400_x", int'(TankX), 4);
        check("left400_heading", int'(Heading), 6);

        // Down clamp
        keycode = 32'h0051_0000;
        step(225);
        check("down225_y", int'(TankY), 475);
        step(10);
        check("down235_y", int'(TankY), 475);
        check("down_heading", int'(Heading), 4);
        check("down_x_hold", int'(TankX), 4);

        // Fire held 40 edges: one pulse, 16 frames not ready
        do_reset();
        keycode       = 32'h0000_002C;
        fire_cnt      = 0;
        not_ready_cnt = 0;
        step(1);
        check("fire_first", int'(Fire), 1);
        check("fire_ready_low", int'(Ready), 0);
        fire_cnt      += int'(Fire);
        not_ready_cnt += int'(!Ready);
        for (int i = 1; i < 40; i++) begin
            step(1);
            fire_cnt      += int'(Fire);
            not_ready_cnt += int'(!Ready);
        end
        check("fire_pulses", fire_cnt, 1);
        check("cooldown_frames", not_ready_cnt, 16);
        check("held_ready", int'(Ready), 1);

        // Fresh press fires again, for one frame only
        keycode = 32'h0;
        step(1);
        check("release_fire", int'(Fire), 0);
        keycode = 32'h002C_0000;
        step(1);
        check("refire", int'(Fire), 1);
        step(1);
        check("refire_drop", int'(Fire), 0);

        // Up + right
        do_reset();
        keycode = 32'h0000_524F;
        step(5);
`ifdef TANK_DIAG_EN
        check("upright_x", int'(TankX), 305);
        check("upright_y", int'(TankY), 245);
        check("upright_heading", int'(Heading), 1);
`else
        check("upright_x", int'(TankX), 300);
        check("upright_y", int'(TankY), 245);
        check("upright_heading", int'(Heading), 0);
`endif

        // Opposing keys resolve by priority
        do_reset();
        keycode = 32'h5100_0052;
        step(3);
        check("updown_y", int'(TankY), 247);
        check("updown_heading", int'(Heading), 0);
        keycode = 32'h004F_5000;
        step(2);
        check("leftright_x", int'(TankX), 298);
        check("leftright_y", int'(TankY), 247);
        check("leftright_heading", int'(Heading), 6);

        // Reset mid-cooldown while moving takes effect immediately
        do_reset();
        keycode = 32'h2C4F_0000;
        step(5);
        check("pre_rst_ready", int'(Ready), 0);
        check("pre_rst_x", int'(TankX), 305);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_ready", int'(Ready), 1);
        check("async_rst_fire", int'(Fire), 0);
        check("async_rst_x", int'(TankX), 300);
        check("async_rst_y", int'(TankY), 250);
        keycode = 32'h0;
        step(1);
        Reset = 1'b0;
        step(2);
        check("post_rst_fire", int'(Fire), 0);
        check("post_rst_x", int'(TankX), 300);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
